// File: rtl/pipe_ctrl_pkg.sv
// ============================================================================
// pipe_ctrl_pkg : shared state encoding and defaults for the pipeline sequencer
// Revision      : 1.0
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        DWAIT = 2'b01,
        HALT  = 2'b10
    } state_e;

    localparam int CNT_W_DEF = 16;

endpackage

`default_nettype wire

// File: rtl/dff.sv
// ============================================================================
// dff      : W-bit register with synchronous active-high reset to RST_VAL
// Revision : 1.0
// ============================================================================
`default_nettype none

module dff #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q_o <= RST_VAL;
        end else begin
            q_o <= d_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl_stall_counter.sv
// ============================================================================
// stall_counter : saturating up-counter with synchronous reset
// Revision      : 1.0
// ============================================================================
`default_nettype none

module stall_counter
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Holds at all-ones rather than wrapping so long stalls never read as short.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// ============================================================================
// pipe_ctrl : five-stage pipeline sequencer - enables, flushes, halt, stall count
// Revision  : 1.0
// ============================================================================
`default_nettype none

module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             imem_done,
    input  logic             dmem_req,
    input  logic             dmem_done,
    input  logic             load_use,
    input  logic             redirect,
    input  logic             MW_halt,
    output logic             pc_en,
    output logic             fd_en,
    output logic             dx_en,
    output logic             xm_en,
    output logic             mw_en,
    output logic             fd_flush,
    output logic             dx_flush,
    output logic             mw_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    logic [1:0] state_bits_q;
    state_e     state_q;
    state_e     state_d;
    logic       drop_q;
    logic       drop_d;
    logic       halted_q;
    logic       halted_d;
    logic       dstall;
    logic       stall_inc;

    assign state_q = state_e'(state_bits_q);
    assign dstall  = (dmem_req | (state_q == DWAIT)) & ~dmem_done;

    always_comb begin
        pc_en    = 1'b0;
        fd_en    = 1'b0;
        dx_en    = 1'b0;
        xm_en    = 1'b0;
        mw_en    = 1'b0;
        fd_flush = 1'b0;
        dx_flush = 1'b0;
        mw_flush = 1'b0;
        state_d  = state_q;
        drop_d   = drop_q;
        halted_d = halted_q;

        if (rst || (state_q == HALT)) begin
            state_d = state_q;
        end else if (MW_halt) begin
            state_d  = HALT;
            halted_d = 1'b1;
        end else if (dstall) begin
            // Everything upstream of MW is frozen, so redirect/load_use are stale.
            mw_en    = 1'b1;
            mw_flush = 1'b1;
            state_d  = DWAIT;
        end else begin
            state_d = RUN;
            if (redirect) begin
                pc_en    = 1'b1;
                fd_en    = 1'b1;
                dx_en    = 1'b1;
                xm_en    = 1'b1;
                mw_en    = 1'b1;
                fd_flush = 1'b1;
                dx_flush = 1'b1;
                drop_d   = ~imem_done;
            end else if (load_use) begin
                dx_en    = 1'b1;
                dx_flush = 1'b1;
                xm_en    = 1'b1;
                mw_en    = 1'b1;
            end else if (!imem_done || drop_q) begin
                // An orphaned fetch must finish before the new PC's fetch starts.
                fd_en    = 1'b1;
                fd_flush = 1'b1;
                dx_en    = 1'b1;
                xm_en    = 1'b1;
                mw_en    = 1'b1;
                if (drop_q && imem_done) begin
                    drop_d = 1'b0;
                end
            end else begin
                pc_en = 1'b1;
                fd_en = 1'b1;
                dx_en = 1'b1;
                xm_en = 1'b1;
                mw_en = 1'b1;
            end
        end
    end

    assign stall_inc = ~pc_en & (state_q != HALT) & ~rst;

    dff #(.W(2), .RST_VAL(RUN)) u_state_dff (
        .clk (clk),
        .rst (rst),
        .d_i (state_d),
        .q_o (state_bits_q)
    );

    dff #(.W(1), .RST_VAL(1'b0)) u_drop_dff (
        .clk (clk),
        .rst (rst),
        .d_i (drop_d),
        .q_o (drop_q)
    );

    dff #(.W(1), .RST_VAL(1'b0)) u_halted_dff (
        .clk (clk),
        .rst (rst),
        .d_i (halted_d),
        .q_o (halted_q)
    );

    stall_counter #(.CNT_W(CNT_W)) u_stall_counter (
        .clk   (clk),
        .rst   (rst),
        .inc_i (stall_inc),
        .cnt_o (stall_cnt)
    );

    assign halted = halted_q;

endmodule

`default_nettype wire
